link_bringup_ctrl: RTL and testbench

Sequences bring-up of the 4-lane 10G SFP+ PHY and its MACs on the DE5 bridge board. Runs on the 50 MHz management clock. Waits for Si570 reference-clock programming to finish, then pulses PHY reset and waits for PLL lock and per-lane TX/RX ready. Releases MAC reset only once the link has been stable for a programmable time, and restarts the sequence on a soft-reset request, a lock loss or a lane drop.

---
 rtl/link_ctrl_pkg.sv | 17 +
 rtl/sync2.sv | 23 ++
 rtl/link_bringup_ctrl.sv | 141 ++++++++++++++
 tb/tb_link_bringup_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/link_ctrl_pkg.sv
// Shared types and widths for the SFP+ link bring-up controller.
package link_ctrl_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_CLK   = 3'd1,
        ST_PHY_RST    = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_WAIT_READY = 3'd4,
        ST_STABLE     = 3'd5,
        ST_UP         = 3'd6
    } link_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, asynchronous active-low reset to zero.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/link_bringup_ctrl.sv
// Bring-up sequencer for the 4-lane SFP+ PHY and MACs on the 50 MHz management clock.
// Optional drop counter enabled by defining LINK_CTRL_DROP_CNT_EN.
module link_bringup_ctrl
    import link_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned PHY_RST_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned STABLE_CYCLES  = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_reset,
    input  logic                  clk_init_busy,
    input  logic                  pll_locked,
    input  logic [NUM_LANES-1:0]  tx_ready,
    input  logic [NUM_LANES-1:0]  rx_ready,
    output logic                  phy_rst,
    output logic                  mac_rst_n,
    output logic                  link_up,
    output logic [STATE_W-1:0]    state,
    output logic                  timeout,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned MAX_AB  = (PHY_RST_CYCLES > LOCK_TIMEOUT) ? PHY_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned SYNC_W  = 2 * NUM_LANES + 1;

    localparam logic [CNT_W-1:0] PHY_RST_LAST = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_W-1:0]    sync_q;
    logic                 lock_s;
    logic                 all_ok;
    link_state_e          state_q;
    link_state_e          state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 timeout_c;

    sync2 #(.WIDTH(SYNC_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({pll_locked, tx_ready, rx_ready}),
        .q     (sync_q)
    );

    assign lock_s = sync_q[SYNC_W-1];
    assign all_ok = lock_s & (&sync_q[2*NUM_LANES-1:NUM_LANES]) & (&sync_q[NUM_LANES-1:0]);

    // Next state, timeout event and shared counter; soft_reset overrides everything.
    always_comb begin
        state_d   = state_q;
        timeout_c = 1'b0;
        cnt_d     = cnt_q;

        if (soft_reset) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:    state_d = ST_WAIT_CLK;
                ST_WAIT_CLK: if (!clk_init_busy) state_d = ST_PHY_RST;
                ST_PHY_RST:  if (cnt_q == PHY_RST_LAST) state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_WAIT_READY;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d   = ST_PHY_RST;
                        timeout_c = 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    if (!lock_s) begin
                        state_d = ST_PHY_RST;
                    end else if (all_ok) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d   = ST_PHY_RST;
                        timeout_c = 1'b1;
                    end
                end
                ST_STABLE:   if (all_ok && cnt_q == STABLE_LAST) state_d = ST_UP;
                ST_UP:       if (!all_ok) state_d = ST_PHY_RST;
                default:     state_d = ST_RESET;
            endcase
        end

        // A glitch in STABLE restarts the qualification window without leaving the state.
        if (state_d != state_q || state_q == ST_RESET) begin
            cnt_d = '0;
        end else if (state_q == ST_STABLE && !all_ok) begin
            cnt_d = '0;
        end else if (state_q inside {ST_PHY_RST, ST_WAIT_LOCK, ST_WAIT_READY, ST_STABLE}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are registered decodes of the next state so they track the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            phy_rst   <= 1'b1;
            mac_rst_n <= 1'b0;
            link_up   <= 1'b0;
            state     <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phy_rst   <= (state_d == ST_RESET) || (state_d == ST_WAIT_CLK) || (state_d == ST_PHY_RST);
            mac_rst_n <= (state_d == ST_UP);
            link_up   <= (state_d == ST_UP);
            state     <= state_d;
            timeout   <= timeout_c;
        end
    end

`ifdef LINK_CTRL_DROP_CNT_EN
    logic                  drop_c;
    logic [DROP_CNT_W-1:0] drop_q;

    assign drop_c     = (state_q == ST_UP) && !soft_reset && !all_ok;
    assign drop_count = drop_q;

    // Saturating count of link drops out of UP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop_c && drop_q != {DROP_CNT_W{1'b1}}) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_link_bringup_ctrl.sv
// Directed self-checking bench for link_bringup_ctrl (short timing parameters).
module tb_link_bringup_ctrl;

`ifdef LINK_CTRL_DROP_CNT_EN
    localparam int unsigned DROP_ONE = 1;
    localparam int unsigned DROP_SAT = 255;
`else
    localparam int unsigned DROP_ONE = 0;
    localparam int unsigned DROP_SAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_reset;
    logic       clk_init_busy;
    logic       pll_locked;
    logic [3:0] tx_ready;
    logic [3:0] rx_ready;
    logic       phy_rst;
    logic       mac_rst_n;
    logic       link_up;
    logic [2:0] state;
    logic       timeout;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    link_bringup_ctrl #(
        .NUM_LANES      (4),
        .PHY_RST_CYCLES (8),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .soft_reset    (soft_reset),
        .clk_init_busy (clk_init_busy),
        .pll_locked    (pll_locked),
        .tx_ready      (tx_ready),
        .rx_ready      (rx_ready),
        .phy_rst       (phy_rst),
        .mac_rst_n     (mac_rst_n),
        .link_up       (link_up),
        .state         (state),
        .timeout       (timeout),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic busy, input logic lock, input logic [3:0] tx, input logic [3:0] rx);
        rst_n         = 1'b0;
        soft_reset    = 1'b0;
        clk_init_busy = busy;
        pll_locked    = lock;
        tx_ready      = tx;
        rx_ready      = rx;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (state == tgt);
        end
    endtask

    initial begin
        int   f_pr, n_pr, f_wl, f_wr, f_st, n_st, f_up, f_mac, f_phy0, n_to;
        int   t1, t2, t3, n_ph, mac_seen;
        logic ok, ok_all;

        // Reset values while rst_n is held low
        rst_n = 1'b0; soft_reset = 1'b0; clk_init_busy = 1'b1; pll_locked = 1'b0;
        tx_ready = '0; rx_ready = '0;
        tick();
        check_eq("rst_phy_rst", 32'(phy_rst), 1);
        check_eq("rst_mac_rst_n", 32'(mac_rst_n), 0);
        check_eq("rst_link_up", 32'(link_up), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_timeout", 32'(timeout), 0);
        check_eq("rst_drop", 32'(drop_count), 0);

        // Nominal: busy falls at 10, lock at 30, readies at 40
        apply_reset(1'b1, 1'b0, 4'h0, 4'h0);
        f_pr = 0; n_pr = 0; f_wl = 0; f_wr = 0; f_st = 0; n_st = 0; f_up = 0; f_mac = 0; f_phy0 = 0; n_to = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (state == 3'd2) begin n_pr++; if (f_pr == 0) f_pr = c; end
            if (state == 3'd3 && f_wl == 0) f_wl = c;
            if (state == 3'd4 && f_wr == 0) f_wr = c;
            if (state == 3'd5) begin n_st++; if (f_st == 0) f_st = c; end
            if (state == 3'd6 && f_up == 0) f_up = c;
            if (mac_rst_n && f_mac == 0) f_mac = c;
            if (!phy_rst && f_phy0 == 0) f_phy0 = c;
            if (timeout) n_to++;
            if (c == 10) clk_init_busy = 1'b0;
            if (c == 30) pll_locked = 1'b1;
            if (c == 40) begin tx_ready = 4'hF; rx_ready = 4'hF; end
        end
        check_eq("nom_phy_rst_entry", f_pr, 11);
        check_eq("nom_phy_rst_len", n_pr, 8);
        check_eq("nom_phy_rst_fall", f_phy0, 19);
        check_eq("nom_wait_lock_entry", f_wl, 19);
        check_eq("nom_wait_ready_entry", f_wr, 33);
        check_eq("nom_stable_entry", f_st, 43);
        check_eq("nom_stable_len", n_st, 16);
        check_eq("nom_up_entry", f_up, 59);
        check_eq("nom_mac_release", f_mac, 59);
        check_eq("nom_link_up", 32'(link_up), 1);
        check_eq("nom_no_timeout", n_to, 0);
        check_eq("nom_drop", 32'(drop_count), 0);

        // Lock never asserts: periodic timeouts, each followed by 8 cycles of phy_rst
        apply_reset(1'b0, 1'b0, 4'h0, 4'h0);
        n_to = 0; t1 = 0; t2 = 0; t3 = 0; n_ph = 0; mac_seen = 0;
        for (int c = 1; c <= 130; c++) begin
            tick();
            if (timeout) begin
                n_to++;
                if (n_to == 1) t1 = c;
                if (n_to == 2) t2 = c;
                if (n_to == 3) t3 = c;
            end
            if (c >= 42 && c <= 81 && phy_rst) n_ph++;
            if (mac_rst_n) mac_seen = 1;
        end
        check_eq("to_count", n_to, 3);
        check_eq("to_first", t1, 42);
        check_eq("to_second", t2, 82);
        check_eq("to_third", t3, 122);
        check_eq("to_phy_pulse_len", n_ph, 8);
        check_eq("to_mac_held", mac_seen, 0);

        // rx_ready[2] glitches for one cycle mid-STABLE
        apply_reset(1'b0, 1'b1, 4'hF, 4'hF);
        f_st = 0; n_st = 0; f_up = 0; f_pr = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (state == 3'd5) begin n_st++; if (f_st == 0) f_st = c; end
            if (state == 3'd6 && f_up == 0) f_up = c;
            if (state == 3'd2 && c > 12) f_pr = c;
            if (c == 16) rx_ready[2] = 1'b0;
            if (c == 17) rx_ready[2] = 1'b1;
        end
        check_eq("gl_stable_entry", f_st, 12);
        check_eq("gl_stable_len", n_st, 23);
        check_eq("gl_up_entry", f_up, 35);
        check_eq("gl_no_phy_rst", f_pr, 0);
        check_eq("gl_drop", 32'(drop_count), 0);

        // Drop tx_ready[0] in UP
        tx_ready[0] = 1'b0;
        tick(); tick(); tick();
        check_eq("drop_mac_rst_n", 32'(mac_rst_n), 0);
        check_eq("drop_link_up", 32'(link_up), 0);
        check_eq("drop_state", 32'(state), 2);
        check_eq("drop_count_1", 32'(drop_count), DROP_ONE);
        tx_ready[0] = 1'b1;

        // soft_reset coincident with a synchronised lane drop
        wait_state(3'd6, 80, ok);
        check_eq("sr_reach_up", 32'(ok), 1);
        rx_ready[1] = 1'b0;
        tick(); tick();
        soft_reset = 1'b1;
        tick();
        check_eq("sr_state", 32'(state), 0);
        check_eq("sr_mac_rst_n", 32'(mac_rst_n), 0);
        check_eq("sr_drop", 32'(drop_count), DROP_ONE);
        soft_reset  = 1'b0;
        rx_ready[1] = 1'b1;
        tick();
        check_eq("sr_wait_clk", 32'(state), 1);
        wait_state(3'd6, 100, ok);
        check_eq("sr_rerun_up", 32'(ok), 1);
        check_eq("sr_drop_after", 32'(drop_count), DROP_ONE);

        // 300 more drops saturate the counter
        ok_all = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tx_ready[0] = 1'b0;
            wait_state(3'd2, 6, ok);
            ok_all &= ok;
            tx_ready[0] = 1'b1;
            wait_state(3'd6, 60, ok);
            ok_all &= ok;
        end
        check_eq("sat_loop", 32'(ok_all), 1);
        check_eq("sat_drop", 32'(drop_count), DROP_SAT);

        // rst_n asserted mid-PHY_RST: outputs return without a clock edge
        tx_ready[0] = 1'b0;
        wait_state(3'd2, 6, ok);
        check_eq("mid_reach_phy_rst", 32'(ok), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_phy_rst", 32'(phy_rst), 1);
        check_eq("mid_mac_rst_n", 32'(mac_rst_n), 0);
        check_eq("mid_link_up", 32'(link_up), 0);
        check_eq("mid_state", 32'(state), 0);
        check_eq("mid_timeout", 32'(timeout), 0);
        check_eq("mid_drop", 32'(drop_count), 0);

        // Held soft_reset keeps the FSM in RESET
        rst_n      = 1'b1;
        soft_reset = 1'b1;
        tick(); tick(); tick();
        check_eq("hold_state", 32'(state), 0);
        check_eq("hold_phy_rst", 32'(phy_rst), 1);
        soft_reset = 1'b0;
        tick();
        check_eq("hold_release", 32'(state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
